// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: adds WIDTH-bit operands one CHUNK-bit slice per clock, LSB first,
// with a registered inter-slice carry and valid/ready handshakes on both sides.
module wide_add_sequencer #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned CHUNK = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK) != 0 || WIDTH == 0) begin : g_bad_width
    $error("wide_add_sequencer: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, work_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;

  logic [CHUNK:0]         chunk_sum;
  logic [WIDTH+CHUNK-1:0] work_shift;
  logic [WIDTH-1:0]       work_d;
  logic                   last_chunk;

  // Operands shift right each RUN edge, so the adder always reads the low slice and no
  // variable-index mux sits in front of it; finished slices enter the working sum from the top.
  assign chunk_sum  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
  assign work_shift = {chunk_sum[CHUNK-1:0], work_q};
  assign work_d     = work_shift[WIDTH+CHUNK-1:CHUNK];
  assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            work_q  <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          work_q  <= work_d;
          carry_q <= chunk_sum[CHUNK];
          if (last_chunk) begin
            sum     <= work_d;
            cout    <= chunk_sum[CHUNK];
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and random checks of wide_add_sequencer at CHUNK=32 (main), CHUNK=8 and CHUNK=128.
module tb_wide_add_sequencer;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         reset, in_valid, out_ready, cin;
  logic [W-1:0] a, b;

  logic         in_ready, out_valid, cout;
  logic [W-1:0] sum;
  logic         in_ready_8, out_valid_8, cout_8;
  logic [W-1:0] sum_8;
  logic         in_ready_1, out_valid_1, cout_1;
  logic [W-1:0] sum_1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.WIDTH(W), .CHUNK(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  wide_add_sequencer #(.WIDTH(W), .CHUNK(8)) dut_n16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_8), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid_8), .out_ready(out_ready), .sum(sum_8), .cout(cout_8)
  );

  wide_add_sequencer #(.WIDTH(W), .CHUNK(128)) dut_n1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_1), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid_1), .out_ready(out_ready), .sum(sum_1), .cout(cout_1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair to the main DUT and return just after the accept edge.
  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    int k = 0;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    while (!in_ready && k < 50) begin tick(); k++; end
    n_vec++;
    if (!in_ready) begin n_err++; $display("FAIL accept_timeout: in_ready=%b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int k = 0;
    while (!out_valid && k < 100) begin tick(); k++; end
    n_vec++;
    if (!out_valid) begin n_err++; $display("FAIL result_timeout: out_valid=%b required 1", out_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_vec++; if ({cout, sum} !== '0) begin n_err++; $display("FAIL reset_sum: got %h_%h required 0", cout, sum); end
    n_vec++;
    if ({in_ready_8, out_valid_8, cout_8, sum_8, in_ready_1, out_valid_1, cout_1, sum_1} !==
        {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b0, {W{1'b0}}}) begin
      n_err++; $display("FAIL reset_other_params: got %b%b/%b%b required 10/10",
                        in_ready_8, out_valid_8, in_ready_1, out_valid_1);
    end
    repeat (3) tick();
    n_vec++;
    if ({in_ready, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}}) begin
      n_err++; $display("FAIL reset_idle_hold: got rdy=%b vld=%b sum=%h", in_ready, out_valid, sum);
    end
  endtask

  task automatic test_carry_full();
    int lat = 0;
    out_ready = 1'b1;
    accept('1, 128'd1, 1'b0);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL busy_in_ready: got %b required 0", in_ready); end
    while (!out_valid && lat < 20) begin tick(); lat++; end
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL latency: got %0d required 4", lat); end
    n_vec++; if (sum !== '0) begin n_err++; $display("FAIL full_carry_sum: got %h required 0", sum); end
    n_vec++; if (cout !== 1'b1) begin n_err++; $display("FAIL full_carry_cout: got %b required 1", cout); end
    tick();
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL release: got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_inter_chunk();
    out_ready = 1'b1;
    accept(128'hFFFF_FFFF, '0, 1'b1);
    wait_result();
    n_vec++;
    if ({cout, sum} !== {1'b0, 128'h1_0000_0000}) begin
      n_err++; $display("FAIL inter_chunk: got %b_%h required 0_100000000", cout, sum);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic stable = 1'b1;
    out_ready = 1'b0;
    accept(128'h8000_0000_0000_0000_0000_0000_0000_0000,
           128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1);
    wait_result();
    n_vec++;
    if ({cout, sum} !== {1'b1, 128'd1}) begin
      n_err++; $display("FAIL bp_first: got %b_%h required 1_1", cout, sum);
    end
    a = 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0000;
    b = 128'h0000_0001_0000_0000_0000_0001_0000_0000;
    cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({out_valid, in_ready, cout, sum} !== {1'b1, 1'b0, 1'b1, 128'd1}) stable = 1'b0;
    end
    n_vec++; if (stable !== 1'b1) begin n_err++; $display("FAIL bp_hold: got stable=%b required 1", stable); end
    out_ready = 1'b1;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    wait_result();
    n_vec++;
    if ({cout, sum} !== {1'b1, 128'h0000_0000_0000_0001_0000_0000_0000_0000}) begin
      n_err++; $display("FAIL bp_second: got %b_%h required 1_00000000000000010000000000000000",
                        cout, sum);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    logic rose = 1'b0;
    out_ready = 1'b1;
    accept('1, '1, 1'b1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if ({in_ready, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}}) begin
      n_err++; $display("FAIL mid_reset_state: got rdy=%b vld=%b sum=%b_%h", in_ready, out_valid, cout, sum);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) rose = 1'b1;
    end
    n_vec++; if (rose !== 1'b0) begin n_err++; $display("FAIL mid_reset_abort: out_valid rose=%b required 0", rose); end
    accept(128'd5, 128'd7, 1'b0);
    wait_result();
    n_vec++;
    if ({cout, sum} !== {1'b0, 128'd12}) begin
      n_err++; $display("FAIL post_reset_add: got %b_%h required 0_c", cout, sum);
    end
    tick();
  endtask

  // All three instances take the same operands; each must match the same sum with its own latency.
  task automatic test_chunk_params();
    logic [W-1:0] va [5] = '{'1, 128'hFF, 128'd5, '1, '0};
    logic [W-1:0] vb [5] = '{128'd1, 128'd1, 128'd7, '1, '0};
    logic         vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W:0]   ve [5] = '{{1'b1, {W{1'b0}}}, {1'b0, 128'h100}, {1'b0, 128'd12},
                             {1'b1, {W{1'b1}}}, {1'b0, 128'd1}};
    out_ready = 1'b1;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int v = 0; v < 5; v++) begin
      int l32 = -1, l8 = -1, l1 = -1;
      logic [W:0] r32 = '0, r8 = '0, r1 = '0;
      a = va[v]; b = vb[v]; cin = vc[v]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int t = 1; t <= 40; t++) begin
        if (out_valid && l32 < 0) begin l32 = t - 1; r32 = {cout, sum}; end
        if (out_valid_8 && l8 < 0) begin l8 = t - 1; r8 = {cout_8, sum_8}; end
        if (out_valid_1 && l1 < 0) begin l1 = t - 1; r1 = {cout_1, sum_1}; end
        tick();
      end
      n_vec++; if (r32 !== ve[v]) begin n_err++; $display("FAIL p32_sum[%0d]: got %h required %h", v, r32, ve[v]); end
      n_vec++; if (r8 !== ve[v]) begin n_err++; $display("FAIL p8_sum[%0d]: got %h required %h", v, r8, ve[v]); end
      n_vec++; if (r1 !== ve[v]) begin n_err++; $display("FAIL p128_sum[%0d]: got %h required %h", v, r1, ve[v]); end
      n_vec++;
      if (l32 != 4 || l8 != 16 || l1 != 1) begin
        n_err++; $display("FAIL p_latency[%0d]: got %0d/%0d/%0d required 4/16/1", v, l32, l8, l1);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   exp_r;
      int           k = 0;
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      exp_r = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      out_ready = 1'($urandom_range(0, 1));
      accept(ra, rb, rc);
      while (!out_valid && k < 20) begin out_ready = 1'($urandom_range(0, 1)); tick(); k++; end
      n_vec++;
      if ({cout, sum} !== exp_r) begin
        n_err++; $display("FAIL random[%0d]: got %h required %h", n, {cout, sum}, exp_r);
      end
      k = 0;
      while (out_valid && k < 50) begin out_ready = 1'($urandom_range(0, 1)); tick(); k++; end
    end
  endtask

  initial begin
    test_reset();
    test_carry_full();
    test_inter_chunk();
    test_backpressure();
    test_mid_reset();
    test_chunk_params();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
